// File: rtl/mem_copy_engine_if.sv
// Memory bus between the copy engine (initiator) and the synchronous memory blocks (responders).
// Read data is registered by the responder, so it is valid in the cycle after the address is presented.
interface mem_copy_engine_if;
    logic [7:0] mem_address;
    logic       mem_WE;
    logic [7:0] mem_data_in;
    logic [7:0] mem_data_out;

    modport master (
        output mem_address,
        output mem_WE,
        output mem_data_in,
        input  mem_data_out
    );

    modport slave (
        input  mem_address,
        input  mem_WE,
        input  mem_data_in,
        output mem_data_out
    );
endinterface

// File: rtl/mem_copy_engine.sv
// Block copy engine: copies `length` bytes from src_addr to dst_addr in ascending order,
// three cycles per byte (READ, LATCH, WRITE), all bus outputs registered from the FSM.
module mem_copy_engine (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [7:0]               src_addr,
    input  logic [7:0]               dst_addr,
    input  logic [7:0]               length,
    output logic                     busy,
    output logic                     done,
    mem_copy_engine_if.master        mem
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LATCH,
        S_WRITE,
        S_DONE
    } state_t;

    state_t     state_q;
    logic [7:0] src_q;
    logic [7:0] dst_q;
    logic [7:0] count_q;
    logic [7:0] buf_q;
    logic [7:0] addr_q;
    logic       we_q;
    logic       busy_q;
    logic       done_q;

    // Output registers are loaded with the values of the state being entered,
    // so every output is a clean Moore function of the current state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            src_q   <= 8'd0;
            dst_q   <= 8'd0;
            count_q <= 8'd0;
            buf_q   <= 8'd0;
            addr_q  <= 8'd0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        if (length != 8'd0) begin
                            src_q   <= src_addr;
                            dst_q   <= dst_addr;
                            count_q <= length;
                            addr_q  <= src_addr;
                            state_q <= S_READ;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_READ: begin
                    state_q <= S_LATCH;
                end
                S_LATCH: begin
                    buf_q   <= mem.mem_data_out;
                    addr_q  <= dst_q;
                    we_q    <= 1'b1;
                    state_q <= S_WRITE;
                end
                S_WRITE: begin
                    // buf_q doubles as the write-data register, so clear it outside WRITE
                    we_q  <= 1'b0;
                    buf_q <= 8'd0;
                    if (count_q == 8'd1) begin
                        addr_q  <= 8'd0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        count_q <= count_q - 8'd1;
                        src_q   <= src_q + 8'd1;
                        dst_q   <= dst_q + 8'd1;
                        addr_q  <= src_q + 8'd1;
                        state_q <= S_READ;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign mem.mem_address  = addr_q;
    // A reset landing on a WRITE cycle must suppress that byte's write at the same edge.
    assign mem.mem_WE       = we_q & ~reset;
    assign mem.mem_data_in  = buf_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine: a synchronous RAM responder plus a byte-level
// reference model of the copy (sequential ascending byte moves, 3-cycle bus pattern per byte).
module tb_mem_copy_engine;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] src_addr;
    logic [7:0] dst_addr;
    logic [7:0] length;
    logic       busy;
    logic       done;

    always #5 clk = ~clk;

    mem_copy_engine_if bus ();

    mem_copy_engine dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .length   (length),
        .busy     (busy),
        .done     (done),
        .mem      (bus)
    );

    logic [7:0] ram [256];
    logic [7:0] mdl [256];
    logic       pre_we;
    logic [7:0] pre_addr;
    logic [7:0] pre_data;

    int n_cmp = 0;
    int n_bad = 0;

    // Synchronous memory responder with a bench-side preload port
    always @(posedge clk) begin
        if (pre_we)
            ram[pre_addr] <= pre_data;
        else if (bus.mem_WE)
            ram[bus.mem_address] <= bus.mem_data_in;
        bus.mem_data_out <= ram[bus.mem_address];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        step();
        pre_we   = 1'b0;
        mdl[a]   = d;
    endtask

    function automatic int mem_diff();
        for (int i = 0; i < 256; i++)
            if (ram[i] !== mdl[i]) return i;
        return -1;
    endfunction

    // Drives one copy and walks the expected bus trace cycle by cycle, updating the model.
    // Returns with the bench sitting in cycle 3N+2 (IDLE), so a following start is back-to-back.
    task automatic run_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] n,
                            input bit inject, output int errs, output string info);
        logic [18:0] exp_v;
        logic [18:0] act_v;
        logic [7:0]  b;
        int          total;
        int          i;
        int          ph;
        errs     = 0;
        info     = "";
        b        = 8'h00;
        src_addr = s;
        dst_addr = d;
        length   = n;
        start    = 1'b1;
        step();
        start    = 1'b0;
        src_addr = 8'($urandom);
        dst_addr = 8'($urandom);
        length   = 8'($urandom);
        total    = 3 * int'(n) + 1;
        for (int c = 1; c <= total + 1; c++) begin
            i  = (c - 1) / 3;
            ph = (c - 1) % 3;
            if (c == total + 1) begin
                exp_v = 19'h0;
            end else if (c == total) begin
                exp_v = {3'b110, 8'h00, 8'h00};
            end else if (ph == 0) begin
                b     = mdl[8'(int'(s) + i)];
                exp_v = {3'b100, 8'(int'(s) + i), 8'h00};
            end else if (ph == 1) begin
                exp_v = {3'b100, 8'(int'(s) + i), 8'h00};
            end else begin
                exp_v = {3'b101, 8'(int'(d) + i), b};
            end
            act_v = {busy, done, bus.mem_WE, bus.mem_address, bus.mem_data_in};
            if (act_v !== exp_v) begin
                if (errs == 0)
                    info = $sformatf("cycle %0d {busy,done,we,addr,wdata} got %h required %h",
                                     c, act_v, exp_v);
                errs++;
            end
            if (ph == 2 && c < total) mdl[8'(int'(d) + i)] = b;
            if (inject && c == 4) begin
                start    = 1'b1;
                src_addr = 8'($urandom);
                dst_addr = 8'($urandom);
                length   = 8'($urandom_range(1, 255));
            end
            if (inject && c == 5) start = 1'b0;
            if (c <= total) step();
        end
    endtask

    task automatic test_reset();
        logic [18:0] act_v;
        reset    = 1'b1;
        start    = 1'b1;
        src_addr = 8'd10;
        dst_addr = 8'd20;
        length   = 8'd5;
        for (int k = 0; k < 2; k++) begin
            step();
            act_v = {busy, done, bus.mem_WE, bus.mem_address, bus.mem_data_in};
            n_cmp++;
            if (act_v !== 19'h0) begin
                n_bad++;
                $display("FAIL reset_cycle%0d: outputs %h required 0", k, act_v);
            end
        end
        reset = 1'b0;
        start = 1'b0;
        step();
        act_v = {busy, done, bus.mem_WE, bus.mem_address, bus.mem_data_in};
        n_cmp++;
        if (act_v !== 19'h0) begin
            n_bad++;
            $display("FAIL reset_no_start: outputs %h required 0", act_v);
        end
        $display("test_reset: done");
    endtask

    task automatic test_basic_copy();
        int    errs;
        string info;
        int    md;
        poke(8'd128, 8'h11);
        poke(8'd129, 8'h22);
        poke(8'd130, 8'h33);
        poke(8'd131, 8'h44);
        run_copy(8'd128, 8'd200, 8'd4, 1'b0, errs, info);
        n_cmp++;
        if (errs !== 0) begin
            n_bad++;
            $display("FAIL basic_trace: %0d bad cycles, %s", errs, info);
        end
        n_cmp++;
        if ({ram[200], ram[201], ram[202], ram[203]} !== 32'h11223344) begin
            n_bad++;
            $display("FAIL basic_data: got %h required 11223344",
                     {ram[200], ram[201], ram[202], ram[203]});
        end
        md = mem_diff();
        n_cmp++;
        if (md !== -1) begin
            n_bad++;
            $display("FAIL basic_mem: ram[%0d]=%h required %h", md, ram[md], mdl[md]);
        end
        $display("test_basic_copy: src=128 dst=200 len=4");
    endtask

    task automatic test_zero_length();
        logic [18:0] act_v;
        int          md;
        src_addr = 8'($urandom);
        dst_addr = 8'($urandom);
        length   = 8'd0;
        start    = 1'b1;
        step();
        start = 1'b0;
        act_v = {busy, done, bus.mem_WE, bus.mem_address, bus.mem_data_in};
        n_cmp++;
        if (act_v !== {3'b110, 16'h0}) begin
            n_bad++;
            $display("FAIL zero_cycle1: got %h required %h", act_v, {3'b110, 16'h0});
        end
        step();
        act_v = {busy, done, bus.mem_WE, bus.mem_address, bus.mem_data_in};
        n_cmp++;
        if (act_v !== 19'h0) begin
            n_bad++;
            $display("FAIL zero_cycle2: got %h required 0", act_v);
        end
        md = mem_diff();
        n_cmp++;
        if (md !== -1) begin
            n_bad++;
            $display("FAIL zero_mem: ram[%0d]=%h required %h", md, ram[md], mdl[md]);
        end
        $display("test_zero_length: done");
    endtask

    task automatic test_wrap();
        int    errs;
        string info;
        int    md;
        run_copy(8'd254, 8'd126, 8'd3, 1'b0, errs, info);
        n_cmp++;
        if (errs !== 0) begin
            n_bad++;
            $display("FAIL wrap_trace: %0d bad cycles, %s", errs, info);
        end
        md = mem_diff();
        n_cmp++;
        if (md !== -1) begin
            n_bad++;
            $display("FAIL wrap_mem: ram[%0d]=%h required %h", md, ram[md], mdl[md]);
        end
        $display("test_wrap: src=254 dst=126 len=3");
    endtask

    task automatic test_overlap_ignore();
        int    errs;
        string info;
        int    md;
        poke(8'd128, 8'hAA);
        poke(8'd129, 8'hBB);
        run_copy(8'd128, 8'd129, 8'd3, 1'b1, errs, info);
        n_cmp++;
        if (errs !== 0) begin
            n_bad++;
            $display("FAIL overlap_trace: %0d bad cycles, %s", errs, info);
        end
        n_cmp++;
        if ({ram[128], ram[129], ram[130], ram[131]} !== 32'hAAAAAAAA) begin
            n_bad++;
            $display("FAIL overlap_data: got %h required aaaaaaaa",
                     {ram[128], ram[129], ram[130], ram[131]});
        end
        md = mem_diff();
        n_cmp++;
        if (md !== -1) begin
            n_bad++;
            $display("FAIL overlap_mem: ram[%0d]=%h required %h", md, ram[md], mdl[md]);
        end
        $display("test_overlap_ignore: src=128 dst=129 len=3 with ignored start");
    endtask

    task automatic test_mid_reset();
        logic [7:0]  s;
        logic [7:0]  d;
        logic [18:0] act_v;
        int          md;
        int          errs;
        string       info;
        s = 8'($urandom_range(0, 63));
        d = 8'($urandom_range(128, 191));
        src_addr = s;
        dst_addr = d;
        length   = 8'd4;
        start    = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 5; k++) step();
        n_cmp++;
        if ({bus.mem_WE, bus.mem_address} !== {1'b1, 8'(d + 8'd1)}) begin
            n_bad++;
            $display("FAIL midrst_cycle6: {we,addr} got %h required %h",
                     {bus.mem_WE, bus.mem_address}, {1'b1, 8'(d + 8'd1)});
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        mdl[d] = mdl[s];
        act_v = {busy, done, bus.mem_WE, bus.mem_address, bus.mem_data_in};
        n_cmp++;
        if (act_v !== 19'h0) begin
            n_bad++;
            $display("FAIL midrst_outputs: got %h required 0", act_v);
        end
        md = mem_diff();
        n_cmp++;
        if (md !== -1) begin
            n_bad++;
            $display("FAIL midrst_mem: ram[%0d]=%h required %h", md, ram[md], mdl[md]);
        end
        run_copy(8'($urandom), 8'($urandom), 8'($urandom_range(1, 8)), 1'b0, errs, info);
        n_cmp++;
        if (errs !== 0) begin
            n_bad++;
            $display("FAIL midrst_restart: %0d bad cycles, %s", errs, info);
        end
        md = mem_diff();
        n_cmp++;
        if (md !== -1) begin
            n_bad++;
            $display("FAIL midrst_restart_mem: ram[%0d]=%h required %h", md, ram[md], mdl[md]);
        end
        $display("test_mid_reset: src=%0d dst=%0d aborted in second WRITE", s, d);
    endtask

    task automatic test_random();
        logic [7:0] s;
        logic [7:0] d;
        logic [7:0] n;
        int         errs;
        string      info;
        int         md;
        for (int t = 0; t < 7; t++) begin
            s = 8'($urandom);
            d = 8'($urandom);
            n = (t == 6) ? 8'd255 : 8'($urandom_range(1, 24));
            run_copy(s, d, n, 1'b0, errs, info);
            n_cmp++;
            if (errs !== 0) begin
                n_bad++;
                $display("FAIL random%0d_trace: %0d bad cycles, %s", t, errs, info);
            end
            md = mem_diff();
            n_cmp++;
            if (md !== -1) begin
                n_bad++;
                $display("FAIL random%0d_mem: ram[%0d]=%h required %h", t, md, ram[md], mdl[md]);
            end
            $display("test_random: src=%0d dst=%0d len=%0d", s, d, n);
        end
    endtask

    task automatic test_back_to_back();
        int    errs;
        string info;
        int    md;
        for (int t = 0; t < 3; t++) begin
            run_copy(8'($urandom), 8'($urandom), 8'($urandom_range(1, 6)), 1'b0, errs, info);
            n_cmp++;
            if (errs !== 0) begin
                n_bad++;
                $display("FAIL b2b%0d_trace: %0d bad cycles, %s", t, errs, info);
            end
        end
        md = mem_diff();
        n_cmp++;
        if (md !== -1) begin
            n_bad++;
            $display("FAIL b2b_mem: ram[%0d]=%h required %h", md, ram[md], mdl[md]);
        end
        $display("test_back_to_back: 3 copies");
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        src_addr = 8'd0;
        dst_addr = 8'd0;
        length   = 8'd0;
        pre_we   = 1'b0;
        pre_addr = 8'd0;
        pre_data = 8'd0;
        test_reset();
        for (int a = 0; a < 256; a++) poke(8'(a), 8'($urandom));
        test_basic_copy();
        test_zero_length();
        test_wrap();
        test_overlap_ignore();
        test_mid_reset();
        test_random();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
